fetch_sequencer: RTL

- Sequences the instruction executor: fetches each instruction from instruction memory, presents it to the executor and waits for the decode result.
- Computes the next PC from the executor's insn_size / is_branch / branch_pc feedback.
- Sits between the instruction memory port and the executor; provides start, halt and single-step control plus a retired-instruction count.

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches each instruction, issues it to the executor,
// waits for the decode result and computes the next PC. Provides start/halt/single-step control.
module fetch_sequencer #(
   parameter int                  PC_WIDTH   = 16,
   parameter int                  INSN_WIDTH = 40,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int                  CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [PC_WIDTH-1:0]   start_pc,
   input  logic                  halt,
   output logic                  ireq,
   output logic [PC_WIDTH-1:0]   iaddr,
   input  logic                  iack,
   input  logic [INSN_WIDTH-1:0] idata,
   output logic [INSN_WIDTH-1:0] insn,
   output logic                  insn_valid,
   input  logic                  exec_done,
   input  logic                  insn_size,
   input  logic                  is_branch,
   input  logic [PC_WIDTH-1:0]   branch_pc,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  retired
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      EXEC  = 2'd3
   } state_t;

   state_t state;
   logic   halt_pending;

   // Advance is modulo 2^PC_WIDTH; the branch target overrides insn_size entirely.
   logic [PC_WIDTH-1:0] next_pc;
   assign next_pc = is_branch ? branch_pc
                              : pc + (insn_size ? PC_WIDTH'(2) : PC_WIDTH'(1));

   assign iaddr = pc;

   // NOTE: non-blocking assignments throughout, so every branch of the case reads
   // the pre-edge values of pc, retired and halt_pending regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         insn         <= '0;
         ireq         <= 1'b0;
         insn_valid   <= 1'b0;
         busy         <= 1'b0;
         retired      <= '0;
         halt_pending <= 1'b0;
      end else begin
         insn_valid <= 1'b0;
         case (state)
            IDLE: begin
               // A lone halt here is dropped; halt together with start arms single-step.
               if (start) begin
                  pc           <= start_pc;
                  halt_pending <= halt;
                  ireq         <= 1'b1;
                  busy         <= 1'b1;
                  state        <= FETCH;
               end
            end
            FETCH: begin
               if (halt) halt_pending <= 1'b1;
               if (iack) begin
                  insn       <= idata;
                  ireq       <= 1'b0;
                  insn_valid <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (halt) halt_pending <= 1'b1;
               state <= EXEC;
            end
            EXEC: begin
               if (exec_done) begin
                  pc      <= next_pc;
                  retired <= retired + CNT_WIDTH'(1);
                  if (halt_pending || halt) begin
                     halt_pending <= 1'b0;
                     busy         <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     ireq  <= 1'b1;
                     state <= FETCH;
                  end
               end else if (halt) begin
                  halt_pending <= 1'b1;
               end
            end
            default: begin
               ireq  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
